xyolo_databus_mem: RTL and testbench
====================================

# xyolo_databus_mem

Databus responder that terminates the multi-port valid/ready databus driven by the xyolo stage address generators (vread fetch port, vwrite store port) and serves each request from a local wide-word memory. It sits on the far side of a stage's `databus_*` ports in simulation and FPGA bring-up, standing in for the external memory system. Multiple initiators share one memory through round-robin arbitration, with a configurable access latency.

## Interface
- `N_PORTS`, 2: number of initiator ports; port i occupies slice i of every bus.
- `DATABUS_W`, 256: data word width in bits; a multiple of 8 and a power of two.
- `IO_ADDR_W`, 32: byte-address width per port.
- `MEM_ADDR_W`, 10: word-address width of the backing memory (2^MEM_ADDR_W words).
- `LAT`, 2: wait cycles between grant and response; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `databus_valid`  in  N_PORTS  request pending per port.
- `databus_addr`  in  N_PORTS*IO_ADDR_W  byte address per port.
- `databus_wdata`  in  N_PORTS*DATABUS_W  write data per port.
- `databus_wstrb`  in  N_PORTS*DATABUS_W/8  byte strobes per port; all-zero means read.
- `databus_ready`  out  N_PORTS  one-cycle completion pulse per port.
- `databus_rdata`  out  N_PORTS*DATABUS_W  read data per port, valid while ready is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Protocol:
  - The initiator holds valid, addr, wdata and wstrb stable until it samples its ready bit high.
  - Ready pulses for exactly one cycle per request.
  - Valid may remain high after ready to present the next request.
- Word index = addr[MEM_ADDR_W+B-1 : B], where B = log2(DATABUS_W/8). Low B bits are ignored (misaligned addresses are aligned down). Upper bits are ignored, so the address space wraps modulo the memory size.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - If any valid bit is set, grant the first requesting port after `last_grant`, searching cyclically.
    - Register that port's addr, wdata and wstrb; load counter = LAT; go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - Decrement the counter each cycle.
    - When the counter reaches 1, perform the memory access, then go to RESP.
    - Write: update only the bytes whose strobe bit is set.
    - Read: latch the word into the response register.
  - RESP:
    - Assert `databus_ready[grant]`.
    - Drive the response register onto that port's rdata slice; all other slices are 0.
    - Set `last_grant` = grant; go to IDLE.
- For a write, the response register (and rdata) returns the pre-write word contents.
- A valid deasserted after grant does not cancel the request; the access completes and ready still pulses.
- Valid bits of non-granted ports are ignored until the FSM returns to IDLE.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values (async, while rst = 0):
  - FSM = IDLE; `databus_ready` = 0; `databus_rdata` = 0; `busy` = 0.
  - `last_grant` = N_PORTS-1, so port 0 wins first.
  - Counter = 0.
- Reset asserted mid-transaction aborts the transaction. An in-flight write may or may not have reached memory if reset lands on the access edge. No ready pulse is issued after reset.
- Latency: valid sampled in IDLE at cycle t produces ready in cycle t+LAT+1; busy is high in cycles t+1..t+LAT+1.
- Throughput: one request per LAT+2 cycles. A back-to-back request from the same port is granted in the IDLE cycle after RESP.
- Simultaneous requests: a strict rotation means no port waits more than N_PORTS-1 transactions.
- All outputs are registered; no combinational path from inputs to ready or rdata.

## Test plan
- Single write then read:
  - Port 1 writes addr 0x40, wdata = 0xA5 repeated, wstrb all ones; LAT = 2.
  - Required: ready[1] pulses 3 cycles after valid is sampled.
  - Port 0 then reads 0x40: rdata[0] = 0xA5 pattern in the ready cycle; rdata[1] = 0.
- Byte strobes:
  - Write word 5 = all 0x11.
  - Write word 5 with wstrb = 0x0000000F, data all 0xFF.
  - Read back: low 4 bytes = 0xFF, rest = 0x11.
- Arbitration:
  - Both ports hold valid continuously from reset for 4 requests each.
  - Required grant order: 0,1,0,1,…; ready pulses spaced LAT+2 cycles apart.
- Wrap and alignment, MEM_ADDR_W = 10, DATABUS_W = 256:
  - Write via addr 0x1F (aligns to word 0).
  - Read via addr 0x8000 (word 1024, wraps to word 0).
  - Required: read returns the same data.
- Valid drop:
  - Port 0 asserts valid for one cycle only.
  - Required: ready[0] still pulses at t+LAT+1; no second access.
- Reset mid-WAIT:
  - Assert rst = 0 during WAIT of a read.
  - Required: ready stays 0; busy = 0 immediately.
  - After release, a port-1-only request is granted and completes normally.

Source files
------------

// File: rtl/xyolo_databus_mem.sv
// Databus responder for the xyolo address generators: round-robin arbitration
// over N_PORTS initiators, one wide-word memory, fixed access latency LAT.
module xyolo_databus_mem #(
   parameter int N_PORTS    = 2,
   parameter int DATABUS_W  = 256,
   parameter int IO_ADDR_W  = 32,
   parameter int MEM_ADDR_W = 10,
   parameter int LAT        = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_PORTS-1:0]               databus_valid,
   input  logic [N_PORTS*IO_ADDR_W-1:0]     databus_addr,
   input  logic [N_PORTS*DATABUS_W-1:0]     databus_wdata,
   input  logic [N_PORTS*DATABUS_W/8-1:0]   databus_wstrb,
   output logic [N_PORTS-1:0]               databus_ready,
   output logic [N_PORTS*DATABUS_W-1:0]     databus_rdata,
   output logic                             busy
);

   localparam int SW    = DATABUS_W / 8;
   localparam int B     = $clog2(SW);
   localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int DEPTH = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [PW-1:0]         grant_q, grant_d;
   logic [PW-1:0]         last_grant_q, last_grant_d;
   logic [PW-1:0]         arb_sel, cand;
   logic                  arb_hit;
   logic                  req_load, mem_access;

   logic [MEM_ADDR_W-1:0] req_idx;
   logic [DATABUS_W-1:0]  req_wdata;
   logic [SW-1:0]         req_wstrb;
   logic [DATABUS_W-1:0]  mem [DEPTH];

   // Only the word-index bits of each address are decoded; the rest wrap away.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, databus_addr};

   assign busy = (state_q != IDLE);

   // Cyclic search starting one past the last served port
   always_comb begin
      arb_hit = 1'b0;
      arb_sel = last_grant_q;
      cand    = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = PW'((int'(last_grant_q) + k) % N_PORTS);
         if (!arb_hit && databus_valid[cand]) begin
            arb_hit = 1'b1;
            arb_sel = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      req_load     = 1'b0;
      mem_access   = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_hit) begin
               grant_d  = arb_sel;
               cnt_d    = 4'(LAT);
               req_load = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               mem_access = 1'b1;
               cnt_d      = 4'd0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= '0;
         last_grant_q <= PW'(N_PORTS - 1);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Request capture at grant: the initiator may drop valid afterwards
   always_ff @(posedge clk) begin
      if (req_load) begin
         req_idx   <= databus_addr[int'(arb_sel)*IO_ADDR_W + B +: MEM_ADDR_W];
         req_wdata <= databus_wdata[int'(arb_sel)*DATABUS_W +: DATABUS_W];
         req_wstrb <= databus_wstrb[int'(arb_sel)*SW +: SW];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_access) begin
         for (int i = 0; i < SW; i++) begin
            if (req_wstrb[i]) begin
               mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response register: holds the pre-access word, so writes return old data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         databus_ready <= '0;
         databus_rdata <= '0;
      end else begin
         databus_ready <= '0;
         databus_rdata <= '0;
         if (mem_access) begin
            databus_ready[grant_q]                               <= 1'b1;
            databus_rdata[int'(grant_q)*DATABUS_W +: DATABUS_W] <= mem[req_idx];
         end
      end
   end

endmodule

// File: tb/tb_xyolo_databus_mem.sv
// Directed bench for xyolo_databus_mem: handshake latency, strobes, wrap,
// arbitration order, valid drop and reset in the middle of a transaction.
module tb_xyolo_databus_mem;

   localparam int N_PORTS    = 2;
   localparam int DATABUS_W  = 256;
   localparam int IO_ADDR_W  = 32;
   localparam int MEM_ADDR_W = 10;
   localparam int LAT        = 2;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [N_PORTS-1:0]             databus_valid;
   logic [N_PORTS*IO_ADDR_W-1:0]   databus_addr;
   logic [N_PORTS*DATABUS_W-1:0]   databus_wdata;
   logic [N_PORTS*DATABUS_W/8-1:0] databus_wstrb;
   logic [N_PORTS-1:0]             databus_ready;
   logic [N_PORTS*DATABUS_W-1:0]   databus_rdata;
   logic                           busy;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] PAT_A5  = {32{8'hA5}};
   localparam logic [255:0] PAT_11  = {32{8'h11}};
   localparam logic [255:0] PAT_FF  = {32{8'hFF}};
   localparam logic [255:0] PAT_MIX = {{28{8'h11}}, {4{8'hFF}}};
   localparam logic [255:0] PAT_W   = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_5A5A5A5AC3C3C3C3;

   xyolo_databus_mem #(
      .N_PORTS(N_PORTS), .DATABUS_W(DATABUS_W), .IO_ADDR_W(IO_ADDR_W),
      .MEM_ADDR_W(MEM_ADDR_W), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .databus_valid(databus_valid), .databus_addr(databus_addr),
      .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
      .databus_ready(databus_ready), .databus_rdata(databus_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one request; lat counts cycles from the sampling cycle to ready.
   task automatic do_req(input int port, input logic [31:0] addr, input logic [255:0] wdata,
                         input logic [31:0] wstrb, input bit one_shot,
                         output logic [1:0] rdy, output logic [255:0] rd0,
                         output logic [255:0] rd1, output int lat, output logic busy_r);
      int n;
      @(posedge clk); #1;
      databus_valid                = '0;
      databus_valid[port]          = 1'b1;
      databus_addr[port*32 +: 32]  = addr;
      databus_wdata[port*256 +: 256] = wdata;
      databus_wstrb[port*32 +: 32] = wstrb;
      n = 0; lat = -1; rdy = '0; rd0 = '0; rd1 = '0; busy_r = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (one_shot && n == 2) databus_valid[port] = 1'b0;
         if (databus_ready != '0) begin
            rdy    = databus_ready;
            rd0    = databus_rdata[255:0];
            rd1    = databus_rdata[511:256];
            busy_r = busy;
            lat    = n - 1;
            break;
         end
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL req_timeout: port %0d got no ready within 40 cycles", port);
         databus_valid[port] = 1'b0;
      end else if (!one_shot) begin
         @(posedge clk); #1;
         databus_valid[port] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      databus_valid = '0; databus_addr = '0; databus_wdata = '0; databus_wstrb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (databus_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", databus_ready); end
      checks++; if (databus_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", databus_rdata); end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      logic [1:0] rdy; logic [255:0] rd0, rd1; int lat; logic b;
      do_req(1, 32'h40, PAT_A5, 32'hFFFFFFFF, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL wr_ready_port: got %b expected 10", rdy); end
      checks++; if (lat != LAT + 1) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT + 1); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL wr_busy_in_resp: got %b expected 1", b); end
      @(negedge clk);
      checks++; if (databus_ready !== 2'b00) begin errors++; $display("FAIL wr_ready_one_cycle: got %b expected 00", databus_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b expected 0", busy); end
      do_req(0, 32'h40, '0, 32'h0, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL rd_ready_port: got %b expected 01", rdy); end
      checks++; if (rd0 !== PAT_A5) begin errors++; $display("FAIL rd_data: got %h expected %h", rd0, PAT_A5); end
      checks++; if (rd1 !== '0) begin errors++; $display("FAIL rd_other_slice: got %h expected 0", rd1); end
      checks++; if (lat != LAT + 1) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
   endtask

   task automatic test_byte_strobes();
      logic [1:0] rdy; logic [255:0] rd0, rd1; int lat; logic b;
      do_req(0, 32'hA0, PAT_11, 32'hFFFFFFFF, 1'b0, rdy, rd0, rd1, lat, b);
      do_req(1, 32'hA0, PAT_FF, 32'h0000000F, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rd1 !== PAT_11) begin errors++; $display("FAIL strb_prewrite_data: got %h expected %h", rd1, PAT_11); end
      checks++; if (rd0 !== '0) begin errors++; $display("FAIL strb_other_slice: got %h expected 0", rd0); end
      do_req(0, 32'hA0, '0, 32'h0, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rd0 !== PAT_MIX) begin errors++; $display("FAIL strb_readback: got %h expected %h", rd0, PAT_MIX); end
   endtask

   task automatic test_wrap_align();
      logic [1:0] rdy; logic [255:0] rd0, rd1; int lat; logic b;
      do_req(1, 32'h1F, PAT_W, 32'hFFFFFFFF, 1'b0, rdy, rd0, rd1, lat, b);
      do_req(0, 32'h8000, '0, 32'h0, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rd0 !== PAT_W) begin errors++; $display("FAIL wrap_read: got %h expected %h", rd0, PAT_W); end
      do_req(1, 32'h0, '0, 32'h0, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rd1 !== PAT_W) begin errors++; $display("FAIL align_read_word0: got %h expected %h", rd1, PAT_W); end
   endtask

   task automatic test_arbitration();
      int k; int cyc; int prev;
      @(posedge clk); #1;
      rst = 1'b0;
      databus_valid = 2'b11;
      databus_addr  = {32'hA0, 32'h40};
      databus_wstrb = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      k = 0; cyc = 0; prev = 0;
      while (cyc < 80 && k < 8) begin
         @(negedge clk);
         cyc++;
         if (databus_ready != '0) begin
            checks++;
            if (databus_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL arb_order[%0d]: got %b expected %b", k, databus_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            checks++;
            if ((k % 2 == 0) ? (databus_rdata[255:0] !== PAT_A5) : (databus_rdata[511:256] !== PAT_MIX)) begin
               errors++; $display("FAIL arb_rdata[%0d]: got %h", k, databus_rdata);
            end
            if (k > 0) begin
               checks++;
               if (cyc - prev != LAT + 2) begin errors++; $display("FAIL arb_spacing[%0d]: got %0d expected %0d", k, cyc - prev, LAT + 2); end
            end
            prev = cyc;
            k++;
            if (k == 8) databus_valid = 2'b00;
         end
      end
      if (k < 8) begin
         checks++; errors++;
         $display("FAIL arb_timeout: got %0d pulses expected 8", k);
         databus_valid = 2'b00;
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_valid_drop();
      logic [1:0] rdy; logic [255:0] rd0, rd1; int lat; logic b; int extra;
      do_req(0, 32'h40, '0, 32'h0, 1'b1, rdy, rd0, rd1, lat, b);
      checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL drop_ready_port: got %b expected 01", rdy); end
      checks++; if (lat != LAT + 1) begin errors++; $display("FAIL drop_latency: got %0d expected %0d", lat, LAT + 1); end
      checks++; if (rd0 !== PAT_A5) begin errors++; $display("FAIL drop_rdata: got %h expected %h", rd0, PAT_A5); end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (databus_ready != '0 || busy) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL drop_second_access: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_reset_mid_wait();
      logic [1:0] rdy; logic [255:0] rd0, rd1; int lat; logic b; int extra;
      @(posedge clk); #1;
      databus_valid = 2'b01;
      databus_addr[31:0] = 32'h40;
      databus_wstrb = '0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b expected 1", busy); end
      rst = 1'b0;
      databus_valid = 2'b00;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy_now: got %b expected 0", busy); end
      checks++; if (databus_ready !== 2'b00) begin errors++; $display("FAIL rstw_ready_now: got %b expected 00", databus_ready); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (databus_ready != '0 || busy) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL rstw_late_ready: got %0d active cycles expected 0", extra); end
      do_req(1, 32'h40, '0, 32'h0, 1'b0, rdy, rd0, rd1, lat, b);
      checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL rstw_next_port: got %b expected 10", rdy); end
      checks++; if (lat != LAT + 1) begin errors++; $display("FAIL rstw_next_latency: got %0d expected %0d", lat, LAT + 1); end
      checks++; if (rd1 !== PAT_A5) begin errors++; $display("FAIL rstw_next_rdata: got %h expected %h", rd1, PAT_A5); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_strobes();
      test_wrap_align();
      test_arbitration();
      test_valid_drop();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
